matmul_result_writeback: RTL
============================

# matmul_result_writeback

Result-side companion of the matmul unit in the vector processor. It captures the row-per-cycle `c_data` stream produced once a matrix multiply completes, buffers the rows in a small FIFO, and writes them back to the vector register file one row per handshake. Each row `r` goes to destination register `dst_base + r` and carries the instruction's lane mask. It removes the need to stall the writeback port for the full result burst.

## Interface
Parameters:
- `DWIDTH`, 16: element width in bits.
- `NUMLANES`, 8: lanes per row; also rows per result (equals MAT_MUL_SIZE).
- `REGIDWIDTH`, 8: vector register id width.
- `DEPTH`, 8: FIFO depth in rows, a power of 2 and at least 2.

Ports (all single clock domain):
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high reset.
- `arm`  in  1: one-cycle pulse that starts a job; honoured only in IDLE.
- `arm_dst`  in  REGIDWIDTH: base destination register, latched on arm.
- `arm_vmask`  in  NUMLANES: lane write mask, latched on arm.
- `arm_row_mask`  in  NUMLANES: bit r=1 means row r is written back; latched on arm.
- `busy`  out  1: high in COLLECT and DRAIN.
- `c_data_available`  in  1: a result row is present on `c_data` this cycle.
- `c_data`  in  NUMLANES*DWIDTH: one result row; lane 0 is bits [DWIDTH-1:0].
- `wb_valid`  out  1: FIFO head is valid.
- `wb_ready`  in  1: register file accepts the head this cycle.
- `wb_dst`  out  REGIDWIDTH: destination register of the head.
- `wb_data`  out  NUMLANES*DWIDTH: row data of the head.
- `wb_mask`  out  NUMLANES: lane mask for the head.
- `done`  out  1: one-cycle pulse when a job's last row has been accepted.
- `overflow`  out  1: sticky error flag, set when a row is dropped because the FIFO is full.

## Operation
State machine: IDLE, COLLECT, DRAIN.

IDLE
- `arm`=1: latch `arm_dst`, `arm_vmask` and `arm_row_mask`; clear `in_cnt` and `overflow`; go to COLLECT.
- `c_data_available` is ignored.

COLLECT
- Each cycle with `c_data_available`=1 consumes one beat with row index r = `in_cnt`, then `in_cnt` increments.
- If `row_mask[r]`=1, push the entry {`dst_base`+r (mod 2^REGIDWIDTH), `c_data`, `vmask`}.
- If `row_mask[r]`=0, the beat is consumed and no entry is pushed.
- After beat NUMLANES-1 is consumed, go to DRAIN.
- Gaps, i.e. cycles with `c_data_available`=0, are allowed and do not advance `in_cnt`.

DRAIN
- `c_data_available` is ignored.
- Go to IDLE when the FIFO is empty and no push is pending. `done`=1 on the registered transition out of DRAIN.
- A job whose row mask is all zero still produces `done`, on the cycle after DRAIN is entered.

FIFO
- `wb_valid` = not empty. A transfer occurs when `wb_valid` && `wb_ready`, and pops the head.
- While `wb_valid`=1 and `wb_ready`=0, `wb_dst`, `wb_data` and `wb_mask` hold stable.
- Push and pop in the same cycle are allowed at any occupancy, including full.
- Push when full without a same-cycle pop: the row is dropped and `overflow` is set. `overflow` stays set until the next `arm` or `reset`. Overflow is only reachable when DEPTH < NUMLANES.
- `arm` while `busy`=1 is ignored; the job in progress is unaffected.
- Rows leave in arrival order; there is no reordering.

Reset
- `reset`=1 at any point, including mid-job, empties the FIFO and returns to IDLE.
- On reset, all outputs go to 0: `busy`, `wb_valid`, `wb_dst`, `wb_data`, `wb_mask`, `done`, `overflow`.
- The latched job fields and `in_cnt` clear to 0.

## Timing
- The FIFO is registered. A beat pushed at clock edge N gives `wb_valid`=1 (if previously empty) in the cycle after edge N. Capture-to-writeback latency is 1 cycle.
- Pop at edge N: the next head appears in the cycle after edge N, with no bubble while occupancy ≥ 1.
- `busy` rises the cycle after the `arm` edge and falls in the same cycle `done` pulses.
- With `wb_ready` held at 1 and 8 back-to-back beats (all rows enabled), the 8 writebacks occupy 8 consecutive cycles.
- `done` comes 2 cycles after the last beat: 1 cycle for the push, then the pop edge.
- `c_data_available` beats arriving in the same cycle as `arm` are not captured; the first beat counted is in the cycle after arm.

## Test plan
- Basic job: arm with `dst`=8, `vmask`=0xFF, `row_mask`=0xFF; 8 beats where row r lane l = r*16+l; `wb_ready`=1 → `wb_dst` runs 8..15 on consecutive cycles, data matches, `done` is one pulse, `overflow`=0.
- Sparse rows with backpressure: `row_mask`=0xA5, `wb_ready` toggling 1,0,0,1 → writebacks only to `dst_base`+{0,2,5,7}, in order; outputs stay stable during stalls.
- Wrap and empty mask: `arm_dst`=254, `row_mask`=0x0F → `wb_dst` = 254, 255, 0, 1. A separate job with `row_mask`=0x00 → no `wb_valid`; `done` pulses 1 cycle after DRAIN is entered.
- Overflow: DEPTH=4, `wb_ready`=0, 8 beats with all rows enabled → 4 entries kept (rows 0-3) and `overflow`=1. Release `wb_ready` → rows 0-3 drain, then `done`. The next `arm` clears `overflow`.
- Reset and arm handling: `reset` asserted after 3 beats → next cycle `busy`=`wb_valid`=0 and outputs are 0. An `arm` during COLLECT is ignored, and the latched `dst` is unchanged.

Source files
------------

// File: rtl/matmul_result_writeback_if.sv
// Handshake bundle for the matmul result writeback block: job arm, result row stream, regfile writeback.
interface matmul_result_writeback_if #(
  parameter int DWIDTH     = 16,
  parameter int NUMLANES   = 8,
  parameter int REGIDWIDTH = 8
);
  logic                         arm;
  logic [REGIDWIDTH-1:0]        arm_dst;
  logic [NUMLANES-1:0]          arm_vmask;
  logic [NUMLANES-1:0]          arm_row_mask;
  logic                         busy;
  logic                         c_data_available;
  logic [NUMLANES*DWIDTH-1:0]   c_data;
  logic                         wb_valid;
  logic                         wb_ready;
  logic [REGIDWIDTH-1:0]        wb_dst;
  logic [NUMLANES*DWIDTH-1:0]   wb_data;
  logic [NUMLANES-1:0]          wb_mask;
  logic                         done;
  logic                         overflow;

  modport master (
    output arm, arm_dst, arm_vmask, arm_row_mask, c_data_available, c_data, wb_ready,
    input  busy, wb_valid, wb_dst, wb_data, wb_mask, done, overflow
  );

  modport slave (
    input  arm, arm_dst, arm_vmask, arm_row_mask, c_data_available, c_data, wb_ready,
    output busy, wb_valid, wb_dst, wb_data, wb_mask, done, overflow
  );
endinterface

// File: rtl/matmul_result_writeback.sv
// Buffers the row-per-cycle matmul result stream in a FIFO and writes rows back one per wb handshake.
// Push-to-wb_valid latency 1 cycle; head holds while wb_ready is low, rows are dropped (overflow) when full.
module matmul_result_writeback #(
  parameter int DWIDTH     = 16,
  parameter int NUMLANES   = 8,
  parameter int REGIDWIDTH = 8,
  parameter int DEPTH      = 8
) (
  input logic                      clk,
  input logic                      reset,
  matmul_result_writeback_if.slave io
);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW   = AW + 1;
  localparam int ROWIDW = (NUMLANES > 1) ? $clog2(NUMLANES) : 1;
  localparam int ROWW   = NUMLANES * DWIDTH;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  typedef struct packed {
    logic [REGIDWIDTH-1:0] dst;
    logic [ROWW-1:0]       data;
    logic [NUMLANES-1:0]   mask;
  } entry_t;

  state_t                state_q, state_d;
  logic [ROWIDW-1:0]     row_q, row_d;
  logic [REGIDWIDTH-1:0] dst_q, dst_d;
  logic [NUMLANES-1:0]   vmask_q, vmask_d;
  logic [NUMLANES-1:0]   rmask_q, rmask_d;
  logic                  ovf_q, ovf_d;
  logic                  done_q, done_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  entry_t                mem_q [DEPTH];

  entry_t wr_entry;
  entry_t head;
  logic   valid;
  logic   beat, push_req, push, pop, full;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    dst_d    = dst_q;
    vmask_d  = vmask_q;
    rmask_d  = rmask_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    valid    = (count_q != '0);
    pop      = valid && io.wb_ready;
    full     = (count_q == CNTW'(DEPTH));
    beat     = (state_q == COLLECT) && io.c_data_available;
    push_req = beat && rmask_q[row_q];
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    push     = push_req && (!full || pop);

    wr_entry.dst  = dst_q + REGIDWIDTH'(row_q);
    wr_entry.data = io.c_data;
    wr_entry.mask = vmask_q;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNTW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNTW'(1);
    end

    case (state_q)
      IDLE: begin
        if (io.arm) begin
          dst_d   = io.arm_dst;
          vmask_d = io.arm_vmask;
          rmask_d = io.arm_row_mask;
          row_d   = '0;
          ovf_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (beat) begin
          row_d = row_q + ROWIDW'(1);
          if (push_req && !push) begin
            ovf_d = 1'b1;
          end
          if (row_q == ROWIDW'(NUMLANES - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (count_d == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      dst_q    <= '0;
      vmask_q  <= '0;
      rmask_q  <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      dst_q    <= dst_d;
      vmask_q  <= vmask_d;
      rmask_q  <= rmask_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: outputs are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign io.busy     = (state_q != IDLE);
  assign io.wb_valid = valid;
  assign io.wb_dst   = valid ? head.dst  : '0;
  assign io.wb_data  = valid ? head.data : '0;
  assign io.wb_mask  = valid ? head.mask : '0;
  assign io.done     = done_q;
  assign io.overflow = ovf_q;
endmodule
